// File: rtl/mem_wait_responder.sv
// mem_wait_responder
//   Memory-side responder for the cpu_simple bus. It is a word-addressed RAM
//   with byte-lane writes. Each access completes after a fixed number of wait
//   states, plus an optional pseudo-random number of extra ones. This makes
//   the CPU's stall path get exercised. A sticky checker flags an initiator
//   that changes its request while an access is still pending.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   addr       word address; low log2(NUM_WORDS) bits index the RAM (wraps)
//   wdata      write data
//   we         byte-lane write enables (we[i] -> wdata[8i+7:8i])
//   re         read request (ignored when any we bit is set)
//   rdata      read data, valid while mem_ready is high on a read
//   mem_ready  access complete, high for exactly one cycle per access
//   proto_err  sticky: request changed while an access was pending
module mem_wait_responder #(
   parameter int          NUM_WORDS   = 2048,
   parameter int          WAIT_STATES = 0,
   parameter int          RANDOM_WAIT = 0,
   parameter logic [7:0]  LFSR_SEED   = 8'h01,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  we,
   input  logic        re,
   output logic [31:0] rdata,
   output logic        mem_ready,
   output logic        proto_err
);

   localparam int AW = $clog2(NUM_WORDS);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nx;
   logic [4:0]        cnt, cnt_nx;
   logic [7:0]        lfsr;
   logic [4:0]        wait_tot;

   logic [29:0]       cap_addr;
   logic [31:0]       cap_wdata;
   logic [3:0]        cap_we;
   logic              cap_re;

   logic              req;
   logic              capture;
   logic              acc_go;
   logic [AW-1:0]     acc_idx;
   logic [31:0]       acc_wdata;
   logic [3:0]        acc_we;
   logic              acc_rd;
   logic              mismatch;
   logic              do_wr;

   logic [31:0]       ram [NUM_WORDS];

   assign req       = (|we) | re;
   assign mem_ready = (state == DONE);

   // The random term uses the LFSR value before this request advances it.
   assign wait_tot = 5'(WAIT_STATES) +
                     ((RANDOM_WAIT != 0) ? {3'b000, lfsr[1:0]} : 5'd0);

   // Next state and access control
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      capture   = 1'b0;
      acc_go    = 1'b0;
      acc_idx   = cap_addr[AW-1:0];
      acc_wdata = cap_wdata;
      acc_we    = cap_we;
      acc_rd    = cap_re & ~(|cap_we);
      case (state)
         IDLE: begin
            if (req) begin
               capture = 1'b1;
               if (wait_tot == 5'd0) begin
                  // A zero-wait access is serviced straight from the live bus.
                  acc_go    = 1'b1;
                  acc_idx   = addr[AW-1:0];
                  acc_wdata = wdata;
                  acc_we    = we;
                  acc_rd    = re & ~(|we);
                  state_nx  = DONE;
               end else begin
                  cnt_nx   = wait_tot - 5'd1;
                  state_nx = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt != 5'd0) begin
               cnt_nx = cnt - 5'd1;
            end else begin
               acc_go   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign mismatch = (state == BUSY) &&
                     ((addr != cap_addr) || (we != cap_we) ||
                      (re != cap_re) || (wdata != cap_wdata));

   // The RAM has no reset, so a write that coincides with reset must be
   // blocked explicitly here.
   assign do_wr = acc_go & (|acc_we) & ~reset;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (do_wr && acc_we[i])
            ram[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 5'd0;
         lfsr      <= LFSR_SEED;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_we    <= '0;
         cap_re    <= 1'b0;
         rdata     <= '0;
         proto_err <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (capture) begin
            cap_addr  <= addr;
            cap_wdata <= wdata;
            cap_we    <= we;
            cap_re    <= re;
            // x^8+x^6+x^5+x^4+1, Fibonacci form, shifting toward the MSB.
            lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         end
         if (acc_go && acc_rd)
            rdata <= ram[acc_idx];
         if (mismatch)
            proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_wait_responder.sv
module tb_mem_wait_responder;

   logic        clk;
   logic        rst_v   [4];
   logic [29:0] addr_v  [4];
   logic [31:0] wdata_v [4];
   logic [3:0]  we_v    [4];
   logic        re_v    [4];
   wire  [31:0] rdata_v [4];
   wire         rdy_v   [4];
   wire         perr_v  [4];

   int checks = 0;
   int errors = 0;

   // 0: no waits, 1: 3 fixed waits, 2: 2 fixed waits, 3: 1 fixed + random
   mem_wait_responder #(.WAIT_STATES(0)) u_d0 (
      .clk(clk), .reset(rst_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]),
      .we(we_v[0]), .re(re_v[0]), .rdata(rdata_v[0]), .mem_ready(rdy_v[0]),
      .proto_err(perr_v[0]));
   mem_wait_responder #(.WAIT_STATES(3)) u_d1 (
      .clk(clk), .reset(rst_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]),
      .we(we_v[1]), .re(re_v[1]), .rdata(rdata_v[1]), .mem_ready(rdy_v[1]),
      .proto_err(perr_v[1]));
   mem_wait_responder #(.WAIT_STATES(2)) u_d2 (
      .clk(clk), .reset(rst_v[2]), .addr(addr_v[2]), .wdata(wdata_v[2]),
      .we(we_v[2]), .re(re_v[2]), .rdata(rdata_v[2]), .mem_ready(rdy_v[2]),
      .proto_err(perr_v[2]));
   mem_wait_responder #(.WAIT_STATES(1), .RANDOM_WAIT(1), .LFSR_SEED(8'h01)) u_d3 (
      .clk(clk), .reset(rst_v[3]), .addr(addr_v[3]), .wdata(wdata_v[3]),
      .we(we_v[3]), .re(re_v[3]), .rdata(rdata_v[3]), .mem_ready(rdy_v[3]),
      .proto_err(perr_v[3]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Call 1 time unit after a rising edge while the DUT is idle. The task
   // drives the request and counts edges until mem_ready appears; the lat
   // output is that count, or -1 on timeout. It then drops the request and
   // steps one more edge, so the DUT is back in IDLE on return.
   task automatic do_access(input int d, input logic [29:0] a,
                            input logic [31:0] wd, input logic [3:0] w,
                            input logic r, output int lat,
                            output logic [31:0] rd);
      addr_v[d] = a; wdata_v[d] = wd; we_v[d] = w; re_v[d] = r;
      lat = -1; rd = 32'h0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (rdy_v[d]) begin
            lat = c; rd = rdata_v[d];
            break;
         end
      end
      we_v[d] = 4'h0; re_v[d] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (rdy_v[d] !== 1'b0) begin
            errors++; $display("FAIL reset_ready[%0d]: got %b exp 0", d, rdy_v[d]);
         end
         checks++;
         if (rdata_v[d] !== 32'h0) begin
            errors++; $display("FAIL reset_rdata[%0d]: got %h exp 0", d, rdata_v[d]);
         end
         checks++;
         if (perr_v[d] !== 1'b0) begin
            errors++; $display("FAIL reset_proto[%0d]: got %b exp 0", d, perr_v[d]);
         end
      end
   endtask

   task automatic test_zero_wait;
      int lat; logic [31:0] rd;
      do_access(0, 30'd5, 32'hDEADBEEF, 4'hF, 1'b0, lat, rd);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL zw_write_lat: got %0d exp 1", lat); end
      do_access(0, 30'd5, 32'h0, 4'h0, 1'b1, lat, rd);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL zw_read_lat: got %0d exp 1", lat); end
      checks++;
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_read_data: got %h exp deadbeef", rd); end
      checks++;
      if (rdy_v[0] !== 1'b0) begin errors++; $display("FAIL zw_ready_drop: got %b exp 0", rdy_v[0]); end
   endtask

   task automatic test_fixed_wait;
      int lat; logic [31:0] rd;
      do_access(1, 30'd10, 32'h12345678, 4'hF, 1'b0, lat, rd);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL fw_write_lat: got %0d exp 4", lat); end
      do_access(1, 30'd10, 32'h0, 4'h0, 1'b1, lat, rd);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL fw_read_lat: got %0d exp 4", lat); end
      checks++;
      if (rd !== 32'h12345678) begin errors++; $display("FAIL fw_read_data: got %h exp 12345678", rd); end
      checks++;
      if (rdy_v[1] !== 1'b0) begin errors++; $display("FAIL fw_ready_after: got %b exp 0", rdy_v[1]); end
   endtask

   task automatic test_byte_lanes;
      int lat; logic [31:0] rd;
      do_access(0, 30'd7, 32'h11223344, 4'hF, 1'b0, lat, rd);
      do_access(0, 30'd7, 32'hAABBCCDD, 4'b0101, 1'b0, lat, rd);
      do_access(0, 30'd7, 32'h0, 4'h0, 1'b1, lat, rd);
      checks++;
      if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL lanes_merge: got %h exp 11bb33dd", rd); end
      // write plus re counts as a write: rdata must hold the last read value
      do_access(0, 30'd7, 32'h00000000, 4'b1000, 1'b1, lat, rd);
      checks++;
      if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL lanes_wr_re_hold: got %h exp 11bb33dd", rd); end
      checks++;
      if (rdata_v[0] !== 32'h11BB33DD) begin errors++; $display("FAIL lanes_idle_hold: got %h exp 11bb33dd", rdata_v[0]); end
      do_access(0, 30'd7, 32'h0, 4'h0, 1'b1, lat, rd);
      checks++;
      if (rd !== 32'h00BB33DD) begin errors++; $display("FAIL lanes_top_byte: got %h exp 00bb33dd", rd); end
   endtask

   task automatic test_wrap;
      int lat; logic [31:0] rd;
      do_access(0, 30'd2048 + 30'd9, 32'h9E9E1234, 4'hF, 1'b0, lat, rd);
      do_access(0, 30'd9, 32'h0, 4'h0, 1'b1, lat, rd);
      checks++;
      if (rd !== 32'h9E9E1234) begin errors++; $display("FAIL wrap_data: got %h exp 9e9e1234", rd); end
   endtask

   task automatic test_protocol;
      int lat; logic [31:0] rd;
      do_access(2, 30'd21, 32'h0, 4'hF, 1'b0, lat, rd);
      checks++;
      if (perr_v[2] !== 1'b0) begin errors++; $display("FAIL proto_clean: got %b exp 0", perr_v[2]); end
      addr_v[2] = 30'd20; wdata_v[2] = 32'hA5A5A5A5; we_v[2] = 4'hF; re_v[2] = 1'b0;
      @(posedge clk); #1;          // captured, now BUSY
      addr_v[2] = 30'd21;
      @(posedge clk); #1;
      checks++;
      if (perr_v[2] !== 1'b1) begin errors++; $display("FAIL proto_set: got %b exp 1", perr_v[2]); end
      @(posedge clk); #1;
      checks++;
      if (rdy_v[2] !== 1'b1) begin errors++; $display("FAIL proto_complete: got %b exp 1", rdy_v[2]); end
      we_v[2] = 4'h0;
      @(posedge clk); #1;
      do_access(2, 30'd20, 32'h0, 4'h0, 1'b1, lat, rd);
      checks++;
      if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL proto_orig_addr: got %h exp a5a5a5a5", rd); end
      do_access(2, 30'd21, 32'h0, 4'h0, 1'b1, lat, rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL proto_other_addr: got %h exp 0", rd); end
      checks++;
      if (perr_v[2] !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b exp 1", perr_v[2]); end
      rst_v[2] = 1'b1; #2; rst_v[2] = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (perr_v[2] !== 1'b0) begin errors++; $display("FAIL proto_reset: got %b exp 0", perr_v[2]); end
   endtask

   task automatic test_reset_mid;
      int lat; logic [31:0] rd;
      do_access(2, 30'd3, 32'h33333333, 4'hF, 1'b0, lat, rd);
      addr_v[2] = 30'd3; wdata_v[2] = 32'hFFFFFFFF; we_v[2] = 4'hF;
      @(posedge clk); #1;          // write pending in BUSY
      #2 rst_v[2] = 1'b1;
      @(posedge clk); #1;          // request held across an edge under reset
      we_v[2] = 4'h0; rst_v[2] = 1'b0;
      @(posedge clk); #1;
      do_access(2, 30'd3, 32'h0, 4'h0, 1'b1, lat, rd);
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL midrst_next_lat: got %0d exp 3", lat); end
      checks++;
      if (rd !== 32'h33333333) begin errors++; $display("FAIL midrst_word3: got %h exp 33333333", rd); end
      // reset during DONE must drop mem_ready without waiting for an edge
      addr_v[2] = 30'd3; re_v[2] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rdy_v[2] !== 1'b1) begin errors++; $display("FAIL midrst_done: got %b exp 1", rdy_v[2]); end
      #2 rst_v[2] = 1'b1;
      #1;
      checks++;
      if (rdy_v[2] !== 1'b0) begin errors++; $display("FAIL midrst_async_drop: got %b exp 0", rdy_v[2]); end
      checks++;
      if (rdata_v[2] !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h exp 0", rdata_v[2]); end
      re_v[2] = 1'b0; rst_v[2] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      int lat; logic [31:0] rd;
      logic [7:0] l;
      int exp_lat;
      rst_v[3] = 1'b1; #2; rst_v[3] = 1'b0;
      @(posedge clk); #1;
      l = 8'h01;
      for (int i = 0; i < 16; i++) begin
         exp_lat = 1 + 1 + int'(l[1:0]);
         do_access(3, 30'(i), 32'h0, 4'h0, 1'b1, lat, rd);
         checks++;
         if (lat !== exp_lat) begin
            errors++; $display("FAIL rand_lat[%0d]: got %0d exp %0d", i, lat, exp_lat);
         end
         l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
   endtask

   initial begin
      for (int d = 0; d < 4; d++) begin
         rst_v[d] = 1'b1; addr_v[d] = '0; wdata_v[d] = '0; we_v[d] = '0; re_v[d] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      test_reset;
      for (int d = 0; d < 4; d++) rst_v[d] = 1'b0;
      @(posedge clk); #1;
      test_zero_wait;
      test_fixed_wait;
      test_byte_lanes;
      test_wrap;
      test_protocol;
      test_reset_mid;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
